// File: rtl/spi_rx_arbiter.sv
// spi_rx_arbiter: round-robin merge of NUM_CH word streams onto one AXI-Stream port.
// Each grant forwards a burst of up to BURST_LEN words tagged with the channel id.
// The newest accepted word waits in a hold register until the burst end is known,
// so tlast can be attached to it. A stalled channel is closed out after TIMEOUT cycles.
module spi_rx_arbiter #(
   parameter int unsigned DATA_W    = 32,
   parameter int unsigned CH_W      = 2,
   parameter int unsigned BURST_LEN = 4,
   parameter int unsigned TIMEOUT   = 64
) (
   input  logic                             aclk,
   input  logic                             areset,
   input  logic [(1<<CH_W)*DATA_W-1:0]      s_tdata,
   input  logic [(1<<CH_W)-1:0]             s_tvalid,
   output logic [(1<<CH_W)-1:0]             s_tready,
   output logic [DATA_W-1:0]                m_tdata,
   output logic [CH_W-1:0]                  m_tuser,
   output logic                             m_tvalid,
   output logic                             m_tlast,
   input  logic                             m_tready,
   output logic                             busy,
   output logic                             trunc,
   output logic [15:0]                      burst_cnt
);

   localparam int unsigned NUM_CH = 1 << CH_W;
   localparam int unsigned TMR_W  = $clog2(TIMEOUT);
   localparam int unsigned BEAT_W = $clog2(BURST_LEN + 1);

   typedef enum logic [1:0] {StIdle, StBurst, StFlush} state_e;

   state_e              state_q, state_d;
   logic [CH_W-1:0]     rr_ptr_q, rr_ptr_d;
   logic [CH_W-1:0]     grant_q, grant_d;
   logic [BEAT_W-1:0]   beat_q, beat_d;
   logic [TMR_W-1:0]    timer_q, timer_d;
   logic                hold_v_q, hold_v_d;
   logic [DATA_W-1:0]   hold_data_q, hold_data_d;
   logic [CH_W-1:0]     hold_id_q, hold_id_d;
   logic                o_valid_q, o_valid_d;
   logic [DATA_W-1:0]   o_data_q, o_data_d;
   logic [CH_W-1:0]     o_id_q, o_id_d;
   logic                o_last_q, o_last_d;
   logic [15:0]         burst_cnt_q, burst_cnt_d;

   logic                o_free;
   logic                accept;
   logic [DATA_W-1:0]   sel_data;
   logic [CH_W-1:0]     rr_grant;
   logic [CH_W-1:0]     rr_idx;

   assign o_free = !o_valid_q || m_tready;

   // Round-robin pick: first valid channel at or after rr_ptr, wrapping upward.
   always_comb begin
      rr_grant = rr_ptr_q;
      rr_idx   = '0;
      for (int i = NUM_CH - 1; i >= 0; i--) begin
         rr_idx = rr_ptr_q + CH_W'(i);
         if (s_tvalid[rr_idx]) rr_grant = rr_idx;
      end
   end

   // Select the granted channel's word.
   always_comb begin
      sel_data = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         if (grant_q == CH_W'(i)) sel_data = s_tdata[i*DATA_W +: DATA_W];
      end
   end

   // Only the granted channel sees ready, and only while H can drain into O.
   always_comb begin
      s_tready = '0;
      if (state_q == StBurst) s_tready[grant_q] = !hold_v_q || o_free;
   end

   assign accept = s_tvalid[grant_q] && s_tready[grant_q];

   // Next-state, hold/output register loads and timeout handling.
   always_comb begin
      state_d     = state_q;
      rr_ptr_d    = rr_ptr_q;
      grant_d     = grant_q;
      beat_d      = beat_q;
      timer_d     = timer_q;
      hold_v_d    = hold_v_q;
      hold_data_d = hold_data_q;
      hold_id_d   = hold_id_q;
      o_valid_d   = o_valid_q && !m_tready;
      o_data_d    = o_data_q;
      o_id_d      = o_id_q;
      o_last_d    = o_last_q;
      burst_cnt_d = burst_cnt_q;
      trunc       = 1'b0;

      unique case (state_q)
         StIdle: begin
            if (|s_tvalid) begin
               grant_d = rr_grant;
               beat_d  = '0;
               timer_d = '0;
               state_d = StBurst;
            end
         end
         StBurst: begin
            if (accept) begin
               // Previous word is no longer the last one: release it without tlast.
               if (hold_v_q) begin
                  o_valid_d = 1'b1;
                  o_data_d  = hold_data_q;
                  o_id_d    = hold_id_q;
                  o_last_d  = 1'b0;
               end
               hold_v_d    = 1'b1;
               hold_data_d = sel_data;
               hold_id_d   = grant_q;
               beat_d      = beat_q + BEAT_W'(1);
               timer_d     = '0;
               if (beat_q == BEAT_W'(BURST_LEN - 1)) state_d = StFlush;
            end else if (timer_q == TMR_W'(TIMEOUT - 1)) begin
               if (hold_v_q) begin
                  trunc   = 1'b1;
                  state_d = StFlush;
               end else begin
                  rr_ptr_d = grant_q + CH_W'(1);
                  state_d  = StIdle;
               end
            end else begin
               timer_d = timer_q + TMR_W'(1);
            end
         end
         StFlush: begin
            if (o_free) begin
               o_valid_d   = 1'b1;
               o_data_d    = hold_data_q;
               o_id_d      = hold_id_q;
               o_last_d    = 1'b1;
               hold_v_d    = 1'b0;
               rr_ptr_d    = grant_q + CH_W'(1);
               burst_cnt_d = burst_cnt_q + 16'd1;
               state_d     = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // State and datapath registers with synchronous reset.
   always_ff @(posedge aclk) begin
      if (areset) begin
         state_q     <= StIdle;
         rr_ptr_q    <= '0;
         grant_q     <= '0;
         beat_q      <= '0;
         timer_q     <= '0;
         hold_v_q    <= 1'b0;
         hold_data_q <= '0;
         hold_id_q   <= '0;
         o_valid_q   <= 1'b0;
         o_data_q    <= '0;
         o_id_q      <= '0;
         o_last_q    <= 1'b0;
         burst_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         rr_ptr_q    <= rr_ptr_d;
         grant_q     <= grant_d;
         beat_q      <= beat_d;
         timer_q     <= timer_d;
         hold_v_q    <= hold_v_d;
         hold_data_q <= hold_data_d;
         hold_id_q   <= hold_id_d;
         o_valid_q   <= o_valid_d;
         o_data_q    <= o_data_d;
         o_id_q      <= o_id_d;
         o_last_q    <= o_last_d;
         burst_cnt_q <= burst_cnt_d;
      end
   end

   assign m_tdata   = o_data_q;
   assign m_tuser   = o_id_q;
   assign m_tvalid  = o_valid_q;
   assign m_tlast   = o_last_q;
   assign busy      = (state_q != StIdle);
   assign burst_cnt = burst_cnt_q;

endmodule

// File: tb/tb_spi_rx_arbiter.sv
// Bench for spi_rx_arbiter: table of single-channel streams plus hand-written
// multi-cycle sequences; output beats are checked against a queue of expected words.
module tb_spi_rx_arbiter;

   localparam int DATA_W    = 32;
   localparam int CH_W      = 2;
   localparam int NUM_CH    = 4;
   localparam int BURST_LEN = 4;
   localparam int TIMEOUT   = 64;

   logic                       aclk = 1'b0;
   logic                       areset;
   logic [NUM_CH*DATA_W-1:0]   s_tdata;
   logic [NUM_CH-1:0]          s_tvalid;
   logic [NUM_CH-1:0]          s_tready;
   logic [DATA_W-1:0]          m_tdata;
   logic [CH_W-1:0]            m_tuser;
   logic                       m_tvalid;
   logic                       m_tlast;
   logic                       m_tready;
   logic                       busy;
   logic                       trunc;
   logic [15:0]                burst_cnt;

   spi_rx_arbiter #(
      .DATA_W    (DATA_W),
      .CH_W      (CH_W),
      .BURST_LEN (BURST_LEN),
      .TIMEOUT   (TIMEOUT)
   ) dut (
      .aclk      (aclk),
      .areset    (areset),
      .s_tdata   (s_tdata),
      .s_tvalid  (s_tvalid),
      .s_tready  (s_tready),
      .m_tdata   (m_tdata),
      .m_tuser   (m_tuser),
      .m_tvalid  (m_tvalid),
      .m_tlast   (m_tlast),
      .m_tready  (m_tready),
      .busy      (busy),
      .trunc     (trunc),
      .burst_cnt (burst_cnt)
   );

   always #5 aclk = ~aclk;

   typedef struct {
      logic [31:0] data;
      logic [1:0]  user;
      logic        last;
   } beat_t;

   typedef struct {
      int          ch;
      int          n;
      logic [31:0] base;
      int          bursts;
      int          truncs;
   } vec_t;

   beat_t exp_q[$];
   beat_t mon_e;
   vec_t  vecs[4];
   int    total = 0;
   int    bad = 0;
   int    trunc_cnt = 0;
   int    trunc_cyc = 0;
   int    cyc = 0;
   int    acc_cyc = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask

   always @(posedge aclk) cyc <= cyc + 1;

   // Output monitor: count trunc pulses, pop and compare every accepted output beat.
   always @(negedge aclk) begin
      if (!areset) begin
         if (trunc) begin
            trunc_cnt++;
            trunc_cyc = cyc;
         end
         if (m_tvalid && m_tready) begin
            if (exp_q.size() == 0) begin
               total++;
               bad++;
               $display("FAIL unexpected_beat: got data=%0h user=%0d last=%0b want none",
                        m_tdata, m_tuser, m_tlast);
            end else begin
               mon_e = exp_q.pop_front();
               check("beat", {29'd0, m_tuser, m_tlast, m_tdata},
                     {29'd0, mon_e.user, mon_e.last, mon_e.data});
            end
         end
      end
   end

   task automatic push_exp(input int c, input logic [31:0] base, input int n);
      beat_t b;
      for (int k = 0; k < n; k++) begin
         b.data = base + 32'(k);
         b.user = 2'(c);
         b.last = ((k % BURST_LEN) == BURST_LEN - 1) || (k == n - 1);
         exp_q.push_back(b);
      end
   endtask

   // Call at posedge+1; returns at posedge+1 after the last word's accepting edge.
   task automatic drive_words(input int c, input int n, input logic [31:0] base);
      bit got;
      for (int k = 0; k < n; k++) begin
         s_tdata[c*DATA_W +: DATA_W] = base + 32'(k);
         s_tvalid[c] = 1'b1;
         got = 1'b0;
         for (int w = 0; w < 500 && !got; w++) begin
            @(negedge aclk);
            if (s_tready[c]) begin
               got = 1'b1;
               acc_cyc = cyc;
            end
            @(posedge aclk);
            #1;
         end
         if (!got) begin
            total++;
            bad++;
            $display("FAIL drive_timeout: ch%0d word %0d never accepted", c, k);
         end
      end
      s_tvalid[c] = 1'b0;
   endtask

   task automatic wait_idle(input string name);
      bit done;
      done = 1'b0;
      for (int w = 0; w < 300 && !done; w++) begin
         @(negedge aclk);
         if (!busy && !m_tvalid) done = 1'b1;
      end
      if (!done) begin
         total++;
         bad++;
         $display("FAIL %s: busy=%0b m_tvalid=%0b want both 0", name, busy, m_tvalid);
      end
   endtask

   task automatic do_reset();
      @(posedge aclk);
      #1;
      areset   = 1'b1;
      s_tvalid = '0;
      m_tready = 1'b1;
      repeat (2) @(posedge aclk);
      #1;
      areset    = 1'b0;
      exp_q.delete();
      trunc_cnt = 0;
   endtask

   task automatic check_zero(input string name);
      check(name, {23'd0, busy, trunc, m_tvalid, m_tlast, m_tuser, s_tready, burst_cnt}, 64'd0);
      check({name, "_data"}, 64'(m_tdata), 64'd0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int          saved;
      int          cnt[NUM_CH];
      logic [3:0]  acc;
      logic [63:0] snap;
      bit          have;
      bit          done;

      vecs[0] = '{1, 8, 32'hA0, 2, 0};
      vecs[1] = '{2, 5, 32'hB0, 2, 1};
      vecs[2] = '{3, 1, 32'hC0, 1, 1};
      vecs[3] = '{0, 3, 32'hD0, 1, 1};

      areset   = 1'b1;
      s_tvalid = '0;
      s_tdata  = '0;
      m_tready = 1'b1;
      repeat (2) @(posedge aclk);
      @(negedge aclk);
      check_zero("reset_state");
      @(posedge aclk);
      #1;
      areset = 1'b0;

      // Single-channel streams.
      for (int r = 0; r < 4; r++) begin
         do_reset();
         push_exp(vecs[r].ch, vecs[r].base, vecs[r].n);
         drive_words(vecs[r].ch, vecs[r].n, vecs[r].base);
         wait_idle($sformatf("row%0d_idle", r));
         check($sformatf("row%0d_bursts", r), 64'(burst_cnt), 64'(vecs[r].bursts));
         check($sformatf("row%0d_truncs", r), 64'(trunc_cnt), 64'(vecs[r].truncs));
         check($sformatf("row%0d_left", r), 64'(exp_q.size()), 64'd0);
      end

      // Channels 0, 2, 3 always valid: grants rotate 0,2,3,0,2,3.
      do_reset();
      for (int b = 0; b < 2; b++) begin
         push_exp(0, 32'h000 + 32'(b * 4), 4);
         push_exp(2, 32'h200 + 32'(b * 4), 4);
         push_exp(3, 32'h300 + 32'(b * 4), 4);
      end
      for (int c = 0; c < NUM_CH; c++) begin
         cnt[c] = 0;
         s_tdata[c*DATA_W +: DATA_W] = 32'(c * 256);
      end
      s_tvalid = 4'b1101;
      for (int w = 0; w < 600 && s_tvalid != 0; w++) begin
         @(negedge aclk);
         acc = s_tvalid & s_tready;
         @(posedge aclk);
         #1;
         for (int c = 0; c < NUM_CH; c++) begin
            if (acc[c]) begin
               cnt[c]++;
               if (cnt[c] == 8) s_tvalid[c] = 1'b0;
               else s_tdata[c*DATA_W +: DATA_W] = 32'(c * 256 + cnt[c]);
            end
         end
      end
      if (s_tvalid != 0) begin
         total++;
         bad++;
         $display("FAIL rr_drive: s_tvalid=%0b want 0", s_tvalid);
         s_tvalid = '0;
      end
      wait_idle("rr_idle");
      check("rr_bursts", 64'(burst_cnt), 64'd6);
      check("rr_left", 64'(exp_q.size()), 64'd0);

      // Timeout after two words: trunc exactly 64 cycles after the second accept.
      do_reset();
      push_exp(0, 32'hE0, 2);
      drive_words(0, 2, 32'hE0);
      saved = acc_cyc;
      wait_idle("tmo_idle");
      check("tmo_count", 64'(trunc_cnt), 64'd1);
      check("tmo_delay", 64'(trunc_cyc - saved), 64'd64);
      check("tmo_bursts", 64'(burst_cnt), 64'd1);
      check("tmo_left", 64'(exp_q.size()), 64'd0);

      // Downstream stall: output stays stable and ch2 is back-pressured.
      do_reset();
      m_tready = 1'b0;
      push_exp(2, 32'h40, 4);
      fork
         drive_words(2, 4, 32'h40);
         begin
            have = 1'b0;
            snap = '0;
            for (int i = 0; i < 10; i++) begin
               @(negedge aclk);
               if (m_tvalid) begin
                  if (!have) begin
                     snap = {29'd0, m_tuser, m_tlast, m_tdata};
                     have = 1'b1;
                  end else begin
                     check("stall_stable", {29'd0, m_tuser, m_tlast, m_tdata}, snap);
                  end
               end
            end
            check("stall_ready", 64'(s_tready[2]), 64'd0);
            check("stall_valid", 64'(m_tvalid), 64'd1);
            check("stall_data", 64'(m_tdata), 64'h40);
            @(posedge aclk);
            #1;
            m_tready = 1'b1;
         end
      join
      wait_idle("stall_idle");
      check("stall_bursts", 64'(burst_cnt), 64'd1);
      check("stall_left", 64'(exp_q.size()), 64'd0);

      // Reset the cycle after the second accept; nothing of that burst survives.
      do_reset();
      drive_words(1, 2, 32'h50);
      areset = 1'b1;
      @(posedge aclk);
      @(negedge aclk);
      check_zero("rst_mid");
      @(posedge aclk);
      #1;
      areset    = 1'b0;
      exp_q.delete();
      trunc_cnt = 0;
      push_exp(3, 32'h30, 4);
      drive_words(3, 4, 32'h30);
      wait_idle("rst_idle");
      check("rst_bursts", 64'(burst_cnt), 64'd1);
      check("rst_truncs", 64'(trunc_cnt), 64'd0);
      check("rst_left", 64'(exp_q.size()), 64'd0);

      // Word offered exactly on the timer-expiry cycle wins over the timeout.
      do_reset();
      push_exp(0, 32'h60, 4);
      drive_words(0, 1, 32'h60);
      repeat (63) @(posedge aclk);
      #1;
      s_tdata[0 +: DATA_W] = 32'h61;
      s_tvalid[0] = 1'b1;
      @(negedge aclk);
      check("expiry_ready", 64'(s_tready[0]), 64'd1);
      check("expiry_trunc", 64'(trunc), 64'd0);
      @(posedge aclk);
      #1;
      s_tvalid[0] = 1'b0;
      drive_words(0, 2, 32'h62);
      wait_idle("expiry_idle");
      check("expiry_truncs", 64'(trunc_cnt), 64'd0);
      check("expiry_bursts", 64'(burst_cnt), 64'd1);
      check("expiry_left", 64'(exp_q.size()), 64'd0);

      done = 1'b1;
      if (done) begin
         $display("test done: total=%0d bad=%0d", total, bad);
         $finish;
      end
   end

endmodule
